mram_serial_host_if: RTL and testbench

Host-side command serializer that sits directly upstream of MRAM_Top_Module. It accepts one parallel MRAM command (write/read, 20-bit address, 16-bit data) through a valid/ready handshake. It shifts address and data LSB-first onto the addr_in/data_in serial lines with read_write_sel framing, then for reads de-serializes ser_data_out back into a 16-bit word. It gives the FPGA-side logic a word-level interface to the serial MRAM datapath.

---
 rtl/mram_if_pkg.sv | 18 +
 rtl/mram_piso.sv | 25 ++
 rtl/mram_serial_host_if.sv | 140 ++++++++++++++
 tb/tb_mram_serial_host_if.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mram_if_pkg.sv
// Shared constants and types for the host-side serializer and the MRAM datapath.
package mram_if_pkg;

  localparam int MRAM_ADDR_W      = 20;
  localparam int MRAM_DATA_W      = 16;
  localparam int MRAM_ACCESS_WAIT = 8;
  localparam int MRAM_READ_LAT    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE
  } host_state_e;

endpackage

// File: rtl/mram_piso.sv
// Loadable parallel-in/serial-out shift register, LSB first, zero-filled from the top.
module mram_piso #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] din,
  output logic         sout
);

  logic [W-1:0] sr;

  // Load has priority; each shift exposes the next bit at sout.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst)           sr <= '0;
    else if (load)     sr <= din;
    else if (shift_en) sr <= sr >> 1;
  end

  assign sout = sr[0];

endmodule

// File: rtl/mram_serial_host_if.sv
// Word-level command interface that frames, serializes and de-serializes MRAM accesses.
module mram_serial_host_if
  import mram_if_pkg::*;
#(
  parameter int ADDR_W      = MRAM_ADDR_W,
  parameter int DATA_W      = MRAM_DATA_W,
  parameter int ACCESS_WAIT = MRAM_ACCESS_WAIT,
  parameter int READ_LAT    = MRAM_READ_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              addr_in,
  output logic              data_in,
  output logic              read_write_sel,
  input  logic              ser_data_out,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              wr_done,
  output logic              busy
);

  localparam int CNT_MAX = (ACCESS_WAIT > ADDR_W) ? ACCESS_WAIT : ADDR_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  host_state_e       state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [CNT_W-1:0]  wait_last;
  logic              wr_q;
  logic [DATA_W-1:0] cap, cap_next;
  logic              accept, shift_en, addr_bit, data_bit;

  assign accept    = cmd_valid && cmd_ready;
  assign shift_en  = (state_next == ST_SHIFT);
  assign wait_last = wr_q ? CNT_W'(ACCESS_WAIT - 1) : CNT_W'(READ_LAT - 1);
  assign cap_next  = {ser_data_out, cap[DATA_W-1:1]};

  // Address and data serializers; reads load zeros so data_in stays low.
  mram_piso #(.W(ADDR_W)) u_addr_piso (
    .clk(clk), .rst(rst), .load(accept), .shift_en(shift_en),
    .din(cmd_addr), .sout(addr_bit)
  );

  mram_piso #(.W(DATA_W)) u_data_piso (
    .clk(clk), .rst(rst), .load(accept), .shift_en(shift_en),
    .din(cmd_write ? cmd_data : '0), .sout(data_bit)
  );

  // State and phase counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and phase counting.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      ST_IDLE:    if (accept) state_next = ST_SETUP;
      ST_SETUP: begin
        state_next = ST_SHIFT;
        cnt_next   = '0;
      end
      ST_SHIFT: begin
        if (cnt == CNT_W'(ADDR_W - 1)) begin
          state_next = ST_WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt == wait_last) begin
          state_next = wr_q ? ST_DONE : ST_CAPTURE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (cnt == CNT_W'(DATA_W - 1)) begin
          state_next = ST_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Latch the command direction at accept so later cmd_* changes cannot disturb the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         wr_q <= 1'b0;
    else if (accept) wr_q <= cmd_write;
  end

  // Inline SIPO: shifts in from the top so the first sample lands in bit 0.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: this register is reset so an aborted read can never leak stale bits into rd_data.
    if (rst)                        cap <= '0;
    else if (state == ST_CAPTURE)   cap <= cap_next;
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready      <= 1'b0;
      busy           <= 1'b0;
      read_write_sel <= 1'b0;
      addr_in        <= 1'b0;
      data_in        <= 1'b0;
      wr_done        <= 1'b0;
      rd_valid       <= 1'b0;
      rd_data        <= '0;
    end else begin
      cmd_ready      <= (state_next == ST_IDLE);
      busy           <= (state_next != ST_IDLE);
      read_write_sel <= (state_next == ST_IDLE) ? 1'b0 : (accept ? cmd_write : wr_q);
      addr_in        <= shift_en ? addr_bit : 1'b0;
      data_in        <= shift_en ? data_bit : 1'b0;
      wr_done        <= (state_next == ST_DONE) &&  wr_q;
      rd_valid       <= (state_next == ST_DONE) && !wr_q;
      if (state == ST_CAPTURE && state_next == ST_DONE) rd_data <= cap_next;
    end
  end

endmodule

// File: tb/tb_mram_serial_host_if.sv
// Self-checking bench: per-cycle expected output frames queued at stimulus time, popped as the DUT runs.
module tb_mram_serial_host_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [19:0] cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic        addr_in, data_in, read_write_sel;
  logic        ser_data_out = 1'b0;
  logic [15:0] rd_data;
  logic        rd_valid, wr_done, busy;

  int n_cmp = 0;
  int n_err = 0;
  int n_accept = 0;
  logic [15:0] exp_rd = '0;

  typedef struct {
    logic [22:0] val;
    logic [22:0] mask;
  } exp_t;
  exp_t sb[$];

  mram_serial_host_if dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .addr_in(addr_in), .data_in(data_in), .read_write_sel(read_write_sel),
    .ser_data_out(ser_data_out),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_done(wr_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && cmd_valid && cmd_ready) n_accept++;

  // {cmd_ready, busy, read_write_sel, addr_in, data_in, wr_done, rd_valid, rd_data}
  function automatic logic [22:0] obs();
    return {cmd_ready, busy, read_write_sel, addr_in, data_in, wr_done, rd_valid, rd_data};
  endfunction

  // Issue one command at the current negedge and check every cycle until the next IDLE cycle.
  task automatic do_cmd(input bit w, input logic [19:0] a, input logic [15:0] d,
                        input logic [15:0] rword, input bit keep_valid,
                        input bit nw, input logic [19:0] na, input logic [15:0] nd);
    int   lat, guard;
    exp_t e;
    logic [22:0] got;
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_err++;
      $display("FAIL ready_timeout: cmd_ready=%b required 1", cmd_ready);
      return;
    end
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_data = d;
    @(posedge clk);
    lat = w ? 29 : 39;
    for (int c = 0; c <= lat + 1; c++) begin
      logic sa, sd;
      sa = (c >= 1 && c <= 20) ? a[c-1] : 1'b0;
      sd = (w && c >= 1 && c <= 16) ? d[c-1] : 1'b0;
      if (!w && c == lat) exp_rd = rword;
      e.val  = {(c == lat + 1), (c <= lat), (c <= lat) ? w : 1'b0, sa, sd,
                (w && c == lat), (!w && c == lat), exp_rd};
      e.mask = (c == lat) ? 23'h5FFFFF : 23'h7FFFFF;
      sb.push_back(e);
    end
    for (int c = 0; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c == 0) begin
        if (keep_valid) begin
          cmd_write = nw; cmd_addr = na; cmd_data = nd;
        end else begin
          cmd_valid = 1'b0; cmd_write = ~w;
          cmd_addr = 20'($urandom); cmd_data = 16'($urandom);
        end
      end
      ser_data_out = (!w && c >= 23 && c <= 38) ? rword[c-23] : 1'b0;
      e   = sb.pop_front();
      got = obs();
      n_cmp++;
      if ((got & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("FAIL %s cyc %0d: got %h required %h (mask %h)",
                 w ? "write" : "read", c, got, e.val, e.mask);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 20'hFFFFF; cmd_data = 16'hFFFF;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== 23'h0) begin
        n_err++; $display("FAIL reset_hold: got %h required 000000", obs());
      end
    end
    cmd_valid = 1'b0;
    rst = 1'b0;
    exp_rd = '0;
    @(negedge clk);
    n_cmp++;
    if (obs() !== 23'h400000) begin
      n_err++; $display("FAIL reset_release: got %h required 400000", obs());
    end
    @(negedge clk);
    n_cmp++;
    if (obs() !== 23'h400000) begin
      n_err++; $display("FAIL idle_after_reset: got %h required 400000", obs());
    end
  endtask

  task automatic test_write_patterns();
    do_cmd(1'b1, 20'h00000, 16'h03FF, 16'h0, 1'b0, 1'b0, '0, '0);
    do_cmd(1'b1, 20'hA5F3C, 16'h8001, 16'h0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_read();
    do_cmd(1'b0, 20'h00010, 16'hFFFF, 16'hBEEF, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_back_to_back();
    int base;
    base = n_accept;
    do_cmd(1'b1, 20'h5A5A5, 16'hC3C3, 16'h0, 1'b1, 1'b0, 20'h0F00F, 16'h7777);
    do_cmd(1'b0, 20'h0F00F, 16'h7777, 16'h6D2B, 1'b0, 1'b0, '0, '0);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (n_accept - base !== 2) begin
      n_err++; $display("FAIL accept_count: got %0d required 2", n_accept - base);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [19:0] a;
    bit saw_rd_valid;
    a = 20'h00080;
    saw_rd_valid = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_data = '0;
    @(posedge clk);
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c == 0) cmd_valid = 1'b0;
    end
    n_cmp++;
    if (addr_in !== a[7]) begin
      n_err++; $display("FAIL mid_shift_bit7: addr_in=%b required %b", addr_in, a[7]);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== 23'h0) begin
      n_err++; $display("FAIL async_abort: got %h required 000000", obs());
    end
    repeat (2) begin
      @(negedge clk);
      if (rd_valid || wr_done) saw_rd_valid = 1'b1;
    end
    rst = 1'b0;
    exp_rd = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rd_valid || wr_done) saw_rd_valid = 1'b1;
    end
    n_cmp++;
    if (saw_rd_valid) begin
      n_err++; $display("FAIL abort_pulse: done pulse seen=1 required 0");
    end
    n_cmp++;
    if (obs() !== 23'h400000) begin
      n_err++; $display("FAIL idle_after_abort: got %h required 400000", obs());
    end
    do_cmd(1'b0, 20'h00123, 16'h0, 16'h1234, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_write_patterns();
    test_read();
    test_back_to_back();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
